// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types for the hardware stack engine: opcode encoding, FSM state
// encoding and small opcode classification helpers.
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_PUSH  = 3'b001,
        OP_POP   = 3'b010,
        OP_CALL  = 3'b011,
        OP_RET   = 3'b100,
        OP_PEEK  = 3'b101,
        OP_FLUSH = 3'b110,
        OP_RSVD  = 3'b111
    } stack_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } stack_state_t;

    // Opcodes that write a new entry (grow the stack).
    function automatic logic op_is_write(input stack_op_t o);
        return (o == OP_PUSH) || (o == OP_CALL);
    endfunction

    // Opcodes that read the top entry (POP/RET also shrink the stack).
    function automatic logic op_is_read(input stack_op_t o);
        return (o == OP_POP) || (o == OP_RET) || (o == OP_PEEK);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// DEPTH x DATA_W register file backing the stack. One synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
//
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module stack_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_engine.sv
// -----------------------------------------------------------------------------
// stack_engine
// Downward-growing hardware stack with a request/response handshake.
// A request is executed in the cycle it is accepted; its response is held
// until the consumer takes it, and no new request is accepted meanwhile.
//
// Build option: define STACK_ENGINE_GUARD_EN to report overflow/underflow
// through rsp_err and the ovf_sticky/unf_sticky flags. Without it, over/
// underflow is still blocked silently and the flags read 0.
//
// Ports
//   clk, rst      in   clock, synchronous active-high reset
//   op_valid      in   request strobe
//   op[2:0]       in   opcode (see stack_pkg::stack_op_t)
//   wdata         in   push data / return address
//   op_ready      out  request accepted when high together with op_valid
//   rsp_valid     out  response present
//   rsp_ready     in   consumer accepts response
//   rdata         out  popped/peeked word (0 for all other responses)
//   rsp_err       out  request rejected
//   sp            out  stack pointer, DEPTH = empty, 0 = full
//   full, empty   out  decoded from sp
//   ovf_sticky    out  overflow seen since rst/FLUSH (guard build only)
//   unf_sticky    out  underflow seen since rst/FLUSH (guard build only)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; op_ready high
// ST_RESP | response held on rsp_valid/rdata/rsp_err until rsp_ready
// -----------------------------------------------------------------------------
module stack_engine
    import stack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] wdata,
    output logic              op_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rsp_err,
    output logic [PTR_W-1:0]  sp,
    output logic              full,
    output logic              empty,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] SP_EMPTY = PTR_W'(DEPTH);

    stack_state_t      state;
    stack_state_t      state_next;
    stack_op_t         op_cmd;
    logic              exec;
    logic              ovf;
    logic              unf;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [AW-1:0]     mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [PTR_W-1:0]  sp_next;
    logic [DATA_W-1:0] rdata_next;
    logic              err_next;

    assign op_cmd = stack_op_t'(op);
    assign exec   = (state == ST_IDLE) && op_valid && (op_cmd != OP_NOP);

    assign full  = (sp == '0);
    assign empty = (sp == SP_EMPTY);

    assign ovf = op_is_write(op_cmd) && full;
    assign unf = op_is_read(op_cmd) && empty;

    // The top entry lives at mem[sp]; a push writes one slot below it.
    // Address arithmetic wraps in AW bits, so sp==DEPTH maps to DEPTH-1.
    assign mem_we    = exec && op_is_write(op_cmd) && !full;
    assign mem_waddr = sp[AW-1:0] - AW'(1);
    assign mem_raddr = sp[AW-1:0];

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (exec)      state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        op_ready  = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        sp_next    = sp;
        rdata_next = '0;
        unique case (op_cmd)
            OP_PUSH, OP_CALL: begin
                if (!full) sp_next = sp - PTR_W'(1);
            end
            OP_POP, OP_RET: begin
                if (!empty) begin
                    sp_next    = sp + PTR_W'(1);
                    rdata_next = mem_rdata;
                end
            end
            OP_PEEK: begin
                if (!empty) rdata_next = mem_rdata;
            end
            OP_FLUSH: begin
                sp_next = SP_EMPTY;
            end
            default: begin
                sp_next = sp;
            end
        endcase
    end

`ifdef STACK_ENGINE_GUARD_EN
    assign err_next = (op_cmd == OP_RSVD) || ovf || unf;
`else
    assign err_next = (op_cmd == OP_RSVD);
`endif

    // Response registers only change when a request executes, which can only
    // happen in IDLE, so they stay stable for the whole RESP phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp      <= SP_EMPTY;
            rdata   <= '0;
            rsp_err <= 1'b0;
        end else if (exec) begin
            sp      <= sp_next;
            rdata   <= rdata_next;
            rsp_err <= err_next;
        end
    end

`ifdef STACK_ENGINE_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else if (exec) begin
            if (op_cmd == OP_FLUSH) begin
                ovf_sticky <= 1'b0;
                unf_sticky <= 1'b0;
            end else begin
                if (ovf) ovf_sticky <= 1'b1;
                if (unf) unf_sticky <= 1'b1;
            end
        end
    end
`else
    assign ovf_sticky = 1'b0;
    assign unf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_stack_engine.sv
module tb_stack_engine;
    import stack_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int PW    = 5;
`ifdef STACK_ENGINE_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [DW-1:0] wdata = '0;
    logic          op_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rdata;
    logic          rsp_err;
    logic [PW-1:0] sp;
    logic          full, empty, ovf_sticky, unf_sticky;

    stack_engine #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .wdata(wdata),
        .op_ready(op_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rdata(rdata), .rsp_err(rsp_err), .sp(sp), .full(full), .empty(empty),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request for one accepted cycle; record its expected response.
    task automatic issue(input logic [2:0] o, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        check("op_ready_before_issue", op_ready, 1);
        op_valid = 1'b1;
        op       = o;
        wdata    = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'b000;
        if (o != 3'b000) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for a response, compare it against the scoreboard, consume it.
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (rsp_valid === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rdata, e.rdata);
            check({tag, "_rsp_err"}, rsp_err, e.err);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_released"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_sp", sp, DEPTH);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_ovf", ovf_sticky, 0);
        check("rst_unf", unf_sticky, 0);

        // single push, response next cycle
        issue(3'b001, 32'hA5A5_0001, 32'h0, 1'b0);
        check("push1_sp", sp, 15);
        check("push1_rsp_valid", rsp_valid, 1);
        collect("push1");
        issue(3'b010, 32'h0, 32'hA5A5_0001, 1'b0);
        collect("pop1");
        check("pop1_sp", sp, DEPTH);

        // push / call / ret / pop
        issue(3'b001, 32'h11, 32'h0, 1'b0); collect("push11");
        issue(3'b011, 32'h22, 32'h0, 1'b0); collect("call22");
        check("call_sp", sp, 14);
        issue(3'b100, 32'h0, 32'h22, 1'b0); collect("ret");
        issue(3'b010, 32'h0, 32'h11, 1'b0); collect("pop11");
        check("seq_sp", sp, DEPTH);
        check("seq_empty", empty, 1);

        // fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            issue(3'b001, 32'h100 + i, 32'h0, 1'b0);
            collect("fill");
        end
        check("fill_full", full, 1);
        check("fill_sp", sp, 0);
        issue(3'b001, 32'hDEAD_BEEF, 32'h0, GUARD);
        collect("ovf");
        check("ovf_sp", sp, 0);
        check("ovf_sticky", ovf_sticky, GUARD);
        issue(3'b101, 32'h0, 32'h10F, 1'b0);
        collect("peek_top");
        check("peek_sp", sp, 0);
        issue(3'b110, 32'h0, 32'h0, 1'b0);
        collect("flush");
        check("flush_sp", sp, DEPTH);
        check("flush_ovf_clr", ovf_sticky, 0);

        // underflow
        issue(3'b010, 32'h0, 32'h0, GUARD);
        collect("unf_pop");
        check("unf_sp", sp, DEPTH);
        check("unf_sticky", unf_sticky, GUARD);
        issue(3'b101, 32'h0, 32'h0, GUARD);
        collect("unf_peek");
        issue(3'b110, 32'h0, 32'h0, 1'b0);
        collect("flush2");
        check("flush_unf_clr", unf_sticky, 0);

        // reserved opcode
        issue(3'b111, 32'h1234, 32'h0, 1'b1);
        collect("rsvd");
        check("rsvd_sp", sp, DEPTH);

        // NOP: accepted, no response
        issue(3'b000, 32'h9, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("nop_no_rsp", rsp_valid, 0);
        check("nop_sp", sp, DEPTH);

        // backpressure with a concurrent request
        issue(3'b001, 32'h77, 32'h0, 1'b0); collect("push77");
        issue(3'b010, 32'h0, 32'h77, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op       = 3'b001;
            wdata    = 32'h99;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rdata, 32'h77);
            check("bp_op_ready", op_ready, 0);
            @(posedge clk);
            #1;
            check("bp_sp", sp, DEPTH);
        end
        op_valid = 1'b0;
        op       = 3'b000;
        collect("bp_pop");
        check("bp_after_sp", sp, DEPTH);
        check("bp_after_empty", empty, 1);

        // reset while a response is pending
        issue(3'b001, 32'h55, 32'h0, 1'b0);
        check("rstmid_sp_pre", sp, 15);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_sp", sp, DEPTH);
        check("rstmid_op_ready", op_ready, 1);
        check("rstmid_rdata", rdata, 0);

        issue(3'b001, 32'h66, 32'h0, 1'b0); collect("post_push");
        issue(3'b010, 32'h0, 32'h66, 1'b0); collect("post_pop");
        check("post_sp", sp, DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stack word and data-path width.
REQ-002 SHALL have parameter DEPTH, default 16, number of stack entries (power of two, >=2).
REQ-003 SHALL have parameter PTR_W, default $clog2(DEPTH)+1, SP width (holds 0..DEPTH).
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: op_valid input 1 request strobe; op input 3 opcode; wdata input DATA_W push data / return address.
REQ-006 SHALL have ports: op_ready output 1 request accepted when high with op_valid.
REQ-007 SHALL have ports: rsp_valid output 1 response present; rsp_ready input 1 consumer accept; rdata output DATA_W popped/peeked word; rsp_err output 1 request rejected.
REQ-008 SHALL have ports: sp output PTR_W current stack pointer; full output 1; empty output 1; ovf_sticky output 1; unf_sticky output 1.

Function
REQ-009 SHALL decode op: 000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 PEEK, 110 FLUSH, 111 reserved.
REQ-010 SHALL implement FSM states IDLE and RESP; op_ready = (state==IDLE).
REQ-011 SHALL, in IDLE on op_valid with non-NOP op, execute the op that cycle and move to RESP; NOP is accepted with no response and no state change.
REQ-012 SHALL grow downward: PUSH/CALL write mem[sp-1]<=wdata, sp<=sp-1.
REQ-013 SHALL, for POP/RET, register rdata<=mem[sp], sp<=sp+1; PEEK registers rdata<=mem[sp] with sp unchanged.
REQ-014 SHALL, for FLUSH, set sp<=DEPTH; rdata<=0.
REQ-015 SHALL set rdata<=0 for PUSH/CALL responses.
REQ-016 SHALL hold rsp_valid, rdata, rsp_err stable in RESP until rsp_valid&&rsp_ready, then return to IDLE (response latency: 1 cycle after acceptance at minimum).
REQ-017 SHALL NOT accept a request while in RESP (op_valid ignored, op_ready low).
REQ-018 SHALL drive full=(sp==0), empty=(sp==DEPTH) combinationally from registered sp.
REQ-019 SHALL treat PUSH/CALL when full as overflow and POP/RET/PEEK when empty as underflow: no memory write, sp unchanged, rdata=0.
REQ-020 SHALL treat op 111 as an error: no state change, rdata=0, rsp_err=1.
REQ-021 SHALL perform all SP arithmetic modulo 2^PTR_W but never produce sp outside 0..DEPTH (guaranteed by REQ-019).

Reset
REQ-022 SHALL, on rst, set state=IDLE, sp=DEPTH, rsp_valid=0, rdata=0, rsp_err=0, ovf_sticky=0, unf_sticky=0.
REQ-023 SHALL abandon any pending response on rst mid-transaction; stack memory contents are not cleared.

Configuration
REQ-024 SHALL support macro STACK_ENGINE_GUARD_EN.
REQ-025 SHALL, with STACK_ENGINE_GUARD_EN defined, assert rsp_err for overflow/underflow responses and set ovf_sticky/unf_sticky, cleared only by rst or FLUSH.
REQ-026 SHALL, without STACK_ENGINE_GUARD_EN, still block overflow/underflow per REQ-019 but tie rsp_err (except for op 111), ovf_sticky and unf_sticky to 0.

Structure
REQ-027 SHALL place the opcode enum (stack_op_t) and FSM state enum (stack_state_t) in shared package stack_pkg.
REQ-028 SHALL instantiate one sub-module stack_mem: DEPTH x DATA_W register file, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-029 SHALL test: reset, then PUSH 0xA5A5_0001 -> sp 16->15, rsp_valid next cycle, rdata=0, rsp_err=0.
REQ-030 SHALL test: PUSH 0x11, CALL 0x22, RET, POP -> RET rdata=0x22, POP rdata=0x11, final sp=16, empty=1.
REQ-031 SHALL test: 16 PUSHes then 17th PUSH -> full=1, sp=0, 17th rsp_err=1 and ovf_sticky=1 (GUARD_EN); top entry unchanged.
REQ-032 SHALL test: POP on empty -> rdata=0, sp=16, rsp_err=1/unf_sticky=1 with GUARD_EN, both 0 without.
REQ-033 SHALL test: hold rsp_ready=0 for 5 cycles after POP -> rsp_valid/rdata stable, op_ready=0, concurrent op_valid PUSH not executed.
REQ-034 SHALL test: assert rst while in RESP after PUSH -> next cycle state IDLE, sp=16, rsp_valid=0.
